// File: rtl/sss_n_id1_detector.sv
// SSS cell-ID group detector.
// Collects the 127 hard-decided BPSK bits of one SSS symbol, then scores all
// 336 N_id_1 candidates (one per clock) for the N_id_2 latched when the
// search started. It reports the best candidate, the full cell ID and the
// winning match count.
module sss_n_id1_detector #(
    parameter int SSS_LEN    = 127,
    parameter int N_ID_1_MAX = 335
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [1:0] N_id_2_i,
    input  logic       N_id_2_valid_i,
    input  logic       s_axis_in_tdata,
    input  logic       s_axis_in_tvalid,
    output logic [8:0] m_axis_out_tdata,
    output logic       m_axis_out_tvalid,
    output logic [9:0] N_id_o,
    output logic       N_id_valid_o,
    output logic [6:0] score_o
);

    // Builds a 127-bit m-sequence x(i+7) = x(i+tap) xor x(i), seeded 1,0,0,0,0,0,0.
    function automatic logic [126:0] gen_m_seq(input logic [2:0] tap);
        logic [126:0] x;
        x = 127'd0;
        x[0] = 1'b1;
        for (int i = 0; i < 120; i++) begin
            x[i + 7] = x[i + int'(tap)] ^ x[i];
        end
        return x;
    endfunction

    // Counts the ones in a 127-bit vector (result 0..127).
    function automatic logic [6:0] popcount127(input logic [126:0] v);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 0; i < 127; i++) begin
            c = c + {6'd0, v[i]};
        end
        return c;
    endfunction

    localparam logic [126:0] X0_SEQ = gen_m_seq(3'd4);
    localparam logic [126:0] X1_SEQ = gen_m_seq(3'd1);
    localparam logic [6:0]   LAST_BIT_IDX = 7'(SSS_LEN - 1);
    localparam logic [8:0]   LAST_CAND    = 9'(N_ID_1_MAX);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [126:0]   bits_r;
    logic [6:0]     bit_cnt_r;
    logic [1:0]     nid2_r;
    logic [1:0]     nid2_search_r;
    logic [8:0]     cand_r;
    logic [8:0]     best_k_r;
    logic [6:0]     best_score_r;

    logic [1:0]     grp_s;
    logic [8:0]     grp_base_s;
    logic [8:0]     m1_full_s;
    logic [6:0]     m1_s;
    logic [5:0]     m0_s;
    logic [253:0]   rot0_s;
    logic [253:0]   rot1_s;
    logic [126:0]   expected_s;
    logic [6:0]     score_s;
    logic [9:0]     n_id_s;

    // Candidate parameters m0/m1 and the score of the current candidate.
    always_comb begin
        grp_s      = 2'd0;
        grp_base_s = 9'd0;
        if (cand_r >= 9'd224) begin
            grp_s      = 2'd2;
            grp_base_s = 9'd224;
        end else if (cand_r >= 9'd112) begin
            grp_s      = 2'd1;
            grp_base_s = 9'd112;
        end else begin
            grp_s      = 2'd0;
            grp_base_s = 9'd0;
        end
        m1_full_s  = cand_r - grp_base_s;
        m1_s       = m1_full_s[6:0];
        m0_s       = ({4'd0, grp_s} * 6'd15) + ({4'd0, nid2_search_r} * 6'd5);
        // Rotating a doubled copy gives x((n+m) mod 127) at bit n.
        rot0_s     = {X0_SEQ, X0_SEQ} >> m0_s;
        rot1_s     = {X1_SEQ, X1_SEQ} >> m1_s;
        expected_s = ~(rot0_s[126:0] ^ rot1_s[126:0]);
        score_s    = popcount127(~(bits_r ^ expected_s));
        // N_id = 3*N_id_1 + N_id_2, built as k + 2k + N_id_2.
        n_id_s     = {1'b0, best_k_r} + {best_k_r, 1'b0} + {8'd0, nid2_search_r};
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= ST_COLLECT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: collect 127 bits, sweep all candidates, report once.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_COLLECT: begin
                if (s_axis_in_tvalid && (bit_cnt_r == LAST_BIT_IDX)) begin
                    state_next_s = ST_SEARCH;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_SEARCH: begin
                if (cand_r == LAST_CAND) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SEARCH;
                end
            end
            ST_DONE:  state_next_s = ST_COLLECT;
            default:  state_next_s = ST_COLLECT;
        endcase
    end

    // N_id_2 latch; the out-of-range value 3 is ignored.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            nid2_r <= 2'd0;
        end else if (N_id_2_valid_i && (N_id_2_i != 2'd3)) begin
            nid2_r <= N_id_2_i;
        end else begin
            nid2_r <= nid2_r;
        end
    end

    // Bit capture, candidate sweep with best tracking, and registered results.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bits_r            <= 127'd0;
            bit_cnt_r         <= 7'd0;
            nid2_search_r     <= 2'd0;
            cand_r            <= 9'd0;
            best_k_r          <= 9'd0;
            best_score_r      <= 7'd0;
            m_axis_out_tdata  <= 9'd0;
            m_axis_out_tvalid <= 1'b0;
            N_id_o            <= 10'd0;
            N_id_valid_o      <= 1'b0;
            score_o           <= 7'd0;
        end else begin
            m_axis_out_tvalid <= 1'b0;
            N_id_valid_o      <= 1'b0;
            case (state_r)
                ST_COLLECT: begin
                    if (s_axis_in_tvalid) begin
                        bits_r[bit_cnt_r] <= s_axis_in_tdata;
                        if (bit_cnt_r == LAST_BIT_IDX) begin
                            bit_cnt_r     <= 7'd0;
                            cand_r        <= 9'd0;
                            nid2_search_r <= nid2_r;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 7'd1;
                        end
                    end
                end
                ST_SEARCH: begin
                    // Candidate 0 always seeds the best; later ones must beat it strictly.
                    if ((cand_r == 9'd0) || (score_s > best_score_r)) begin
                        best_k_r     <= cand_r;
                        best_score_r <= score_s;
                    end
                    if (cand_r != LAST_CAND) begin
                        cand_r <= cand_r + 9'd1;
                    end
                end
                ST_DONE: begin
                    m_axis_out_tdata  <= best_k_r;
                    N_id_o            <= n_id_s;
                    score_o           <= best_score_r;
                    m_axis_out_tvalid <= 1'b1;
                    N_id_valid_o      <= 1'b1;
                end
                default: begin
                    bit_cnt_r <= 7'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sss_n_id1_detector.sv
// Self-checking bench for sss_n_id1_detector: randomized SSS symbols scored
// against a direct reference model of the candidate correlation.
module tb_sss_n_id1_detector;

    logic       clk_i;
    logic       reset_ni;
    logic [1:0] N_id_2_i;
    logic       N_id_2_valid_i;
    logic       s_axis_in_tdata;
    logic       s_axis_in_tvalid;
    logic [8:0] m_axis_out_tdata;
    logic       m_axis_out_tvalid;
    logic [9:0] N_id_o;
    logic       N_id_valid_o;
    logic [6:0] score_o;

    sss_n_id1_detector dut (
        .clk_i             (clk_i),
        .reset_ni          (reset_ni),
        .N_id_2_i          (N_id_2_i),
        .N_id_2_valid_i    (N_id_2_valid_i),
        .s_axis_in_tdata   (s_axis_in_tdata),
        .s_axis_in_tvalid  (s_axis_in_tvalid),
        .m_axis_out_tdata  (m_axis_out_tdata),
        .m_axis_out_tvalid (m_axis_out_tvalid),
        .N_id_o            (N_id_o),
        .N_id_valid_o      (N_id_valid_o),
        .score_o           (score_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int vectors;
    int miscompares;
    int tb_nid2;
    bit expect_drop;
    bit x0 [127];
    bit x1 [127];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected SSS bit n for candidate k under N_id_2.
    function automatic bit exp_bit(input int k, input int nid2, input int n);
        int m0;
        int m1;
        m0 = 15 * (k / 112) + 5 * nid2;
        m1 = k % 112;
        return !(x0[(n + m0) % 127] ^ x1[(n + m1) % 127]);
    endfunction

    // One clock; samples 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (expect_drop) begin
            check_val("strobe_one_cycle", {31'd0, m_axis_out_tvalid}, 32'd0);
            expect_drop = 1'b0;
        end
    endtask

    task automatic set_nid2(input int v);
        N_id_2_i       = 2'(v);
        N_id_2_valid_i = 1'b1;
        tick();
        N_id_2_valid_i = 1'b0;
        if (v <= 2) tb_nid2 = v;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_tdata"},  {23'd0, m_axis_out_tdata}, 32'd0);
        check_val({tag, "_tvalid"}, {31'd0, m_axis_out_tvalid}, 32'd0);
        check_val({tag, "_nid"},    {22'd0, N_id_o}, 32'd0);
        check_val({tag, "_nidv"},   {31'd0, N_id_valid_o}, 32'd0);
        check_val({tag, "_score"},  {25'd0, score_o}, 32'd0);
    endtask

    // Sends one symbol for candidate k (with flips/gaps), waits for and checks the result.
    task automatic run_symbol(input int k, input int nflips, input bit gaps, input bit junk,
                              input int nid2_chg, input int reset_at);
        bit sym [127];
        bit flipped [127];
        int nid2_used;
        int best_k;
        int best_sc;
        int sc;
        int lat;
        int pos;
        int strobes;
        nid2_used = tb_nid2;
        for (int n = 0; n < 127; n++) begin
            sym[n]     = exp_bit(k, nid2_used, n);
            flipped[n] = 1'b0;
        end
        for (int f = 0; f < nflips; f++) begin
            pos = $urandom_range(0, 126);
            while (flipped[pos]) pos = $urandom_range(0, 126);
            flipped[pos] = 1'b1;
            sym[pos]     = !sym[pos];
        end
        best_k  = 0;
        best_sc = -1;
        for (int c = 0; c < 336; c++) begin
            sc = 0;
            for (int n = 0; n < 127; n++) if (sym[n] == exp_bit(c, nid2_used, n)) sc++;
            if (sc > best_sc) begin
                best_sc = sc;
                best_k  = c;
            end
        end
        for (int n = 0; n < 127; n++) begin
            if (gaps) begin
                s_axis_in_tvalid = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
            s_axis_in_tvalid = 1'b1;
            s_axis_in_tdata  = sym[n];
            tick();
        end
        s_axis_in_tvalid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 400; c++) begin
            if (junk && c < 300) begin
                s_axis_in_tvalid = 1'b1;
                s_axis_in_tdata  = 1'($urandom_range(0, 1));
            end else begin
                s_axis_in_tvalid = 1'b0;
            end
            if (c == 50 && nid2_chg >= 0) begin
                N_id_2_i       = 2'(nid2_chg);
                N_id_2_valid_i = 1'b1;
                if (nid2_chg <= 2) tb_nid2 = nid2_chg;
            end else begin
                N_id_2_valid_i = 1'b0;
            end
            if (c == reset_at) begin
                s_axis_in_tvalid = 1'b0;
                reset_ni = 1'b0;
                #1;
                check_outputs_zero("abort");
                tick();
                tick();
                reset_ni = 1'b1;
                tb_nid2  = 0;
                strobes  = 0;
                repeat (400) begin
                    tick();
                    if (m_axis_out_tvalid) strobes++;
                end
                check_val("abort_no_strobe", strobes, 32'd0);
                return;
            end
            tick();
            if (m_axis_out_tvalid) begin
                lat = c;
                break;
            end
        end
        s_axis_in_tvalid = 1'b0;
        N_id_2_valid_i   = 1'b0;
        check_val("latency",  lat, 32'd337);
        check_val("nid_valid", {31'd0, N_id_valid_o}, 32'd1);
        check_val("n_id_1",   {23'd0, m_axis_out_tdata}, best_k);
        check_val("n_id",     {22'd0, N_id_o}, 3 * best_k + nid2_used);
        check_val("score",    {25'd0, score_o}, best_sc);
        expect_drop = 1'b1;
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        tb_nid2          = 0;
        expect_drop      = 1'b0;
        reset_ni         = 1'b0;
        N_id_2_i         = 2'd0;
        N_id_2_valid_i   = 1'b0;
        s_axis_in_tdata  = 1'b0;
        s_axis_in_tvalid = 1'b0;
        for (int i = 0; i < 127; i++) begin
            x0[i] = (i == 0);
            x1[i] = (i == 0);
        end
        for (int i = 0; i < 120; i++) begin
            x0[i + 7] = x0[i + 4] ^ x0[i];
            x1[i + 7] = x1[i + 1] ^ x1[i];
        end
        repeat (3) tick();
        check_outputs_zero("reset");
        reset_ni = 1'b1;
        tick();

        // Ideal sequences, boundary candidates.
        set_nid2(0);
        run_symbol(0, 0, 1'b0, 1'b0, -1, -1);
        set_nid2(2);
        run_symbol(335, 0, 1'b0, 1'b0, -1, -1);
        set_nid2(1);
        run_symbol(111, 0, 1'b0, 1'b0, -1, -1);
        run_symbol(112, 0, 1'b0, 1'b0, -1, -1);
        run_symbol(223, 0, 1'b0, 1'b0, -1, -1);
        run_symbol(224, 0, 1'b0, 1'b0, -1, -1);
        // Bit errors with tvalid gaps.
        run_symbol(100, 10, 1'b1, 1'b0, -1, -1);
        // Invalid N_id_2 ignored; mid-search update applies to the next search.
        set_nid2(2);
        set_nid2(3);
        run_symbol(50, 0, 1'b0, 1'b0, 0, -1);
        run_symbol(200, 0, 1'b0, 1'b0, -1, -1);
        // Bits during SEARCH are dropped; next symbol back-to-back.
        run_symbol(17, 3, 1'b0, 1'b1, -1, -1);
        run_symbol(300, 0, 1'b0, 1'b0, -1, -1);
        // Reset in the middle of a search.
        set_nid2(1);
        run_symbol(77, 0, 1'b0, 1'b0, -1, 100);
        run_symbol(77, 0, 1'b0, 1'b0, -1, -1);
        // Randomized symbols.
        for (int r = 0; r < 5; r++) begin
            set_nid2($urandom_range(0, 3));
            run_symbol($urandom_range(0, 335), $urandom_range(0, 30),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
